// File: rtl/operand2_stage.sv
// ARM operand2 decode ahead of the barrel shifter, buffered in a 2-entry skid FIFO.
// Define OPERAND2_REGSHIFT_EN to decode register-shift forms; otherwise they report undef.
module operand2_stage #(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        i_bit_i,
  input  logic [11:0] op2_i,
  input  logic [31:0] rm_val_i,
  input  logic [31:0] rs_val_i,
  input  logic        c_in_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] sh_a_o,
  output logic [4:0]  sh_shamt_o,
  output logic [1:0]  sh_sh_o,
  output logic        ovr_en_o,
  output logic [31:0] ovr_val_o,
  output logic        c_out_o,
  output logic        undef_o
);

  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShLsr = 2'b01;
  localparam logic [1:0] ShAsr = 2'b10;
  localparam logic [1:0] ShRor = 2'b11;

  typedef struct packed {
    logic [31:0] sh_a;
    logic [4:0]  shamt;
    logic [1:0]  sh;
    logic        ovr_en;
    logic [31:0] ovr_val;
    logic        c_out;
    logic        undef;
  } payload_t;

  payload_t    dec;
  logic [31:0] imm32;
  logic [63:0] rot_full;
  logic [4:0]  amt;
  logic        lsl_c;
  logic        rsh_c;
  logic        unused_rs;

  assign imm32    = {24'b0, op2_i[7:0]};
  assign rot_full = {imm32, imm32} >> {op2_i[11:8], 1'b0};

`ifdef OPERAND2_REGSHIFT_EN
  logic [7:0] s;
  logic       s_big;
  logic       s_eq32;

  assign s         = rs_val_i[7:0];
  assign s_big     = |s[7:5];
  assign s_eq32    = (s == 8'd32);
  assign amt       = op2_i[4] ? s[4:0] : op2_i[11:7];
  assign unused_rs = ^rs_val_i[31:8];
`else
  assign amt       = op2_i[11:7];
  assign unused_rs = ^rs_val_i;
`endif

  // Carry bits for a non-zero amount below 32: last bit shifted out left / right.
  assign lsl_c = rm_val_i[5'(6'd32 - {1'b0, amt})];
  assign rsh_c = rm_val_i[amt - 5'd1];

  always_comb begin
    dec = '0;
    if (i_bit_i) begin
      dec.sh_a  = imm32;
      dec.sh    = ShRor;
      dec.shamt = {op2_i[11:8], 1'b0};
      dec.c_out = (op2_i[11:8] == 4'd0) ? c_in_i : rot_full[31];
    end else if (!op2_i[4]) begin
      dec.sh_a  = rm_val_i;
      dec.sh    = op2_i[6:5];
      dec.shamt = op2_i[11:7];
      if (op2_i[11:7] == 5'd0) begin
        // A zero amount encodes LSR/ASR #32 and RRX, which the shifter cannot do.
        unique case (op2_i[6:5])
          ShLsl: dec.c_out = c_in_i;
          ShLsr: begin
            dec.ovr_en = 1'b1;
            dec.c_out  = rm_val_i[31];
          end
          ShAsr: begin
            dec.ovr_en  = 1'b1;
            dec.ovr_val = {32{rm_val_i[31]}};
            dec.c_out   = rm_val_i[31];
          end
          ShRor: begin
            dec.ovr_en  = 1'b1;
            dec.ovr_val = {c_in_i, rm_val_i[31:1]};
            dec.c_out   = rm_val_i[0];
          end
        endcase
      end else begin
        dec.c_out = (op2_i[6:5] == ShLsl) ? lsl_c : rsh_c;
      end
    end else begin
`ifdef OPERAND2_REGSHIFT_EN
      if (op2_i[7]) begin
        dec.undef = 1'b1;
      end else if (s == 8'd0) begin
        dec.sh_a  = rm_val_i;
        dec.sh    = ShLsl;
        dec.c_out = c_in_i;
      end else begin
        dec.sh_a = rm_val_i;
        dec.sh   = op2_i[6:5];
        unique case (op2_i[6:5])
          ShLsl, ShLsr: begin
            if (!s_big) begin
              dec.shamt = s[4:0];
              dec.c_out = (op2_i[6:5] == ShLsl) ? lsl_c : rsh_c;
            end else begin
              dec.ovr_en = 1'b1;
              if (s_eq32) dec.c_out = (op2_i[6:5] == ShLsl) ? rm_val_i[0] : rm_val_i[31];
            end
          end
          ShAsr: begin
            if (!s_big) begin
              dec.shamt = s[4:0];
              dec.c_out = rsh_c;
            end else begin
              dec.ovr_en  = 1'b1;
              dec.ovr_val = {32{rm_val_i[31]}};
              dec.c_out   = rm_val_i[31];
            end
          end
          ShRor: begin
            dec.shamt = s[4:0];
            dec.c_out = (s[4:0] == 5'd0) ? rm_val_i[31] : rsh_c;
          end
        endcase
      end
`else
      dec.undef = 1'b1;
`endif
    end
  end

  payload_t   mem_q [Depth];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       in_ready_q;
  logic       push;
  logic       pop;
  payload_t   head;

  assign push  = in_valid_i & in_ready_q;
  assign pop   = (cnt_q != 2'd0) & out_ready_i;
  assign cnt_d = cnt_q + 2'(push) - 2'(pop);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d != 2'(Depth));
      if (push) begin
        mem_q[wr_ptr_q] <= dec;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (cnt_q != 2'd0);
  assign sh_a_o      = head.sh_a;
  assign sh_shamt_o  = head.shamt;
  assign sh_sh_o     = head.sh;
  assign ovr_en_o    = head.ovr_en;
  assign ovr_val_o   = head.ovr_val;
  assign c_out_o     = head.c_out;
  assign undef_o     = head.undef;

endmodule

// File: tb/tb_operand2_stage.sv
// Bench for operand2_stage: decode vector table through a scoreboard, plus
// backpressure, streaming and asynchronous-reset sequences.
module tb_operand2_stage;

  typedef struct packed {
    logic [31:0] sh_a;
    logic [4:0]  shamt;
    logic [1:0]  sh;
    logic        ovr_en;
    logic [31:0] ovr_val;
    logic        c_out;
    logic        undef;
  } exp_t;

  typedef struct {
    logic        i_bit;
    logic [11:0] op2;
    logic [31:0] rm;
    logic [31:0] rs;
    logic        c_in;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, i_bit, c_in, out_valid, out_ready;
  logic [11:0] op2;
  logic [31:0] rm_val, rs_val, sh_a, ovr_val;
  logic [4:0]  sh_shamt;
  logic [1:0]  sh_sh;
  logic        ovr_en, c_out, undef;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur_exp;
  vec_t vecs[$];
  int   pops = 0;

  operand2_stage dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .i_bit_i    (i_bit),
    .op2_i      (op2),
    .rm_val_i   (rm_val),
    .rs_val_i   (rs_val),
    .c_in_i     (c_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sh_a_o     (sh_a),
    .sh_shamt_o (sh_shamt),
    .sh_sh_o    (sh_sh),
    .ovr_en_o   (ovr_en),
    .ovr_val_o  (ovr_val),
    .c_out_o    (c_out),
    .undef_o    (undef)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic exp_t dut_payload();
    return {sh_a, sh_shamt, sh_sh, ovr_en, ovr_val, c_out, undef};
  endfunction

  function automatic vec_t mk(input logic ib, input logic [11:0] o, input logic [31:0] rm,
                              input logic [31:0] rs, input logic ci, input logic [31:0] a,
                              input logic [4:0] amt, input logic [1:0] t, input logic oe,
                              input logic [31:0] ov, input logic co, input logic ud);
    vec_t v;
    v.i_bit = ib; v.op2 = o; v.rm = rm; v.rs = rs; v.c_in = ci;
    v.e = {a, amt, t, oe, ov, co, ud};
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic apply(input vec_t v);
    i_bit = v.i_bit; op2 = v.op2; rm_val = v.rm; rs_val = v.rs; c_in = v.c_in;
    cur_exp = v.e;
  endtask

  // Called at a falling edge: score the handshakes of the coming rising edge, then advance.
  task automatic cycle();
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", 128'(out_valid), 128'(0));
      end else begin
        e = sb.pop_front();
        chk($sformatf("payload#%0d", pops), 128'(dut_payload()), 128'(e));
        pops++;
      end
    end
    if (in_valid && in_ready) sb.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) cycle();
    chk("drain_empty", 128'(sb.size()), 128'(0));
    chk("drain_out_valid", 128'(out_valid), 128'(0));
  endtask

  initial begin
    // Immediate rotate
    vecs.push_back(mk(1, 12'h4FF, 32'h12345678, 0, 0, 32'hFF, 5'd8, 2'd3, 0, 0, 1, 0));
    vecs.push_back(mk(1, 12'h0AB, 32'h0, 0, 1, 32'hAB, 5'd0, 2'd3, 0, 0, 1, 0));
    vecs.push_back(mk(1, 12'h17C, 32'h0, 0, 1, 32'h7C, 5'd2, 2'd3, 0, 0, 0, 0));
    // Immediate shift, zero-amount specials
    vecs.push_back(mk(0, 12'h020, 32'h80000001, 0, 0, 32'h80000001, 0, 2'd1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 12'h060, 32'h3, 0, 1, 32'h3, 0, 2'd3, 1, 32'h80000001, 1, 0));
    vecs.push_back(mk(0, 12'h040, 32'h80000000, 0, 0, 32'h80000000, 0, 2'd2, 1, 32'hFFFFFFFF,
                      1, 0));
    vecs.push_back(mk(0, 12'h040, 32'h7FFFFFFF, 0, 1, 32'h7FFFFFFF, 0, 2'd2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 12'h000, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 2'd0, 0, 0, 1, 0));
    // Immediate shift, non-zero amounts
    vecs.push_back(mk(0, 12'h200, 32'h10000000, 0, 0, 32'h10000000, 5'd4, 2'd0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 12'h080, 32'h7FFFFFFF, 0, 1, 32'h7FFFFFFF, 5'd1, 2'd0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 12'h1A0, 32'h4, 0, 0, 32'h4, 5'd3, 2'd1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 12'hFC0, 32'h40000000, 0, 0, 32'h40000000, 5'd31, 2'd2, 0, 0, 1, 0));
    vecs.push_back(mk(0, 12'h460, 32'h80, 0, 0, 32'h80, 5'd8, 2'd3, 0, 0, 1, 0));
    vecs.push_back(mk(0, 12'h0E0, 32'hFFFFFFFE, 0, 1, 32'hFFFFFFFE, 5'd1, 2'd3, 0, 0, 0, 0));
    // Register form with bit 7 set is never decodable
    vecs.push_back(mk(0, 12'h090, 32'hFFFF, 32'h4, 1, 0, 0, 0, 0, 0, 0, 1));
`ifdef OPERAND2_REGSHIFT_EN
    vecs.push_back(mk(0, 12'h010, 32'h1, 32'd32, 0, 32'h1, 0, 2'd0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 12'h010, 32'h1, 32'd33, 1, 32'h1, 0, 2'd0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 12'h030, 32'h1, 32'h100, 1, 32'h1, 0, 2'd0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 12'h030, 32'h80000000, 32'd32, 0, 32'h80000000, 0, 2'd1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 12'h050, 32'h80000000, 32'd200, 0, 32'h80000000, 0, 2'd2, 1,
                      32'hFFFFFFFF, 1, 0));
    vecs.push_back(mk(0, 12'h070, 32'h80000000, 32'd64, 0, 32'h80000000, 0, 2'd3, 0, 0, 1, 0));
    vecs.push_back(mk(0, 12'h070, 32'h8, 32'd36, 0, 32'h8, 5'd4, 2'd3, 0, 0, 1, 0));
    vecs.push_back(mk(0, 12'h010, 32'h10000000, 32'd4, 0, 32'h10000000, 5'd4, 2'd0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 12'h030, 32'h10, 32'd5, 0, 32'h10, 5'd5, 2'd1, 0, 0, 1, 0));
`else
    vecs.push_back(mk(0, 12'h010, 32'h1, 32'd32, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 12'h0F0, 32'hFFFFFFFF, 32'd7, 1, 0, 0, 0, 0, 0, 0, 1));
`endif

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    apply(vecs[0]);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_payload", 128'(dut_payload()), 128'(0));

    // Table pass: one vector per cycle, consumer always ready
    out_ready = 1'b1;
    in_valid = 1'b1;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      cycle();
    end
    drain();

    // Backpressure: third push must be refused until the consumer drains
    out_ready = 1'b0;
    in_valid = 1'b1;
    apply(vecs[3]); cycle();
    chk("bp_ready_after1", 128'(in_ready), 128'(1));
    apply(vecs[4]); cycle();
    chk("bp_ready_full", 128'(in_ready), 128'(0));
    chk("bp_valid_full", 128'(out_valid), 128'(1));
    apply(vecs[8]); cycle();
    chk("bp_still_full", 128'(in_ready), 128'(0));
    chk("bp_head_stable", 128'(dut_payload()), 128'(vecs[3].e));
    chk("bp_sb_depth", 128'(sb.size()), 128'(2));
    out_ready = 1'b1;
    cycle();
    chk("bp_ready_after_pop", 128'(in_ready), 128'(1));
    cycle();
    in_valid = 1'b0;
    drain();
    chk("bp_pop_count", 128'(pops), 128'(vecs.size() + 3));

    // Streaming at occupancy 1: a result every cycle
    in_valid = 1'b1;
    out_ready = 1'b1;
    apply(vecs[0]); cycle();
    for (int i = 1; i <= 10; i++) begin
      apply(vecs[i]);
      chk($sformatf("stream_valid#%0d", i), 128'(out_valid), 128'(1));
      cycle();
    end
    drain();
    chk("stream_pop_count", 128'(pops), 128'(vecs.size() + 14));

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    in_valid = 1'b1;
    apply(vecs[5]); cycle();
    apply(vecs[6]); cycle();
    in_valid = 1'b0;
    chk("pre_reset_full", 128'(in_ready), 128'(0));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(out_valid), 128'(0));
    chk("async_rst_ready", 128'(in_ready), 128'(1));
    chk("async_rst_payload", 128'(dut_payload()), 128'(0));
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 128'(out_valid), 128'(0));

    // Register-form encoding after reset recovery
    in_valid = 1'b1;
    out_ready = 1'b1;
    apply(vecs[vecs.size() - 2]);
    cycle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand2_stage.md
# operand2_stage

Pipeline stage directly upstream of the barrel shifter. It decodes the 12-bit ARM data-processing operand2 field (immediate-rotate, immediate-shift, register-shift) together with the Rm/Rs register values and the current C flag. It produces the shifter's operand, amount and type, plus a carry-out and an override path for results the 5-bit shifter cannot express (shift ≥32, RRX). Results are buffered in a 2-entry skid buffer with valid/ready handshakes on both sides.

## Interface
- `DEPTH`, 2: skid buffer entries; fixed at 2, not parameterisable beyond that.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream has a decode request.
- `in_ready` out 1: stage can accept; registered.
- `i_bit` in 1: 1 = immediate operand2 form.
- `op2` in 12: instruction bits [11:0].
- `rm_val` in 32: Rm value.
- `rs_val` in 32: Rs value; only [7:0] used.
- `c_in` in 1: current CPSR C.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream consumes head.
- `sh_a` out 32: shifter operand `a`.
- `sh_shamt` out 5: shifter amount.
- `sh_sh` out 2: shifter type (00 LSL, 01 LSR, 10 ASR, 11 ROR).
- `ovr_en` out 1: downstream must use `ovr_val` instead of the shifter output.
- `ovr_val` out 32: override result.
- `c_out` out 1: shifter carry-out.
- `undef` out 1: encoding not supported; all other payload fields are 0.

## Operation
- Immediate (`i_bit`=1): `sh_a`={24'b0,op2[7:0]}, `sh_sh`=11, `sh_shamt`={op2[11:8],1'b0}, `ovr_en`=0. `c_out`=`c_in` if rot==0, else bit 31 of the rotated immediate.
- Immediate shift (`i_bit`=0, op2[4]=0): n=op2[11:7], type=op2[6:5], `sh_a`=`rm_val`.
  - LSL n: `sh_shamt`=n; `c_out`=`c_in` if n==0, else rm[32-n].
  - LSR/ASR with n≠0: `c_out`=rm[n-1].
  - LSR #0 means LSR #32: `ovr_val`=0, `c_out`=rm[31].
  - ASR #0 means ASR #32: `ovr_val`={32{rm[31]}}, `c_out`=rm[31].
  - ROR #0 means RRX: `ovr_val`={`c_in`,rm[31:1]}, `c_out`=rm[0].
  - ROR n≠0: `c_out`=rm[n-1].
- Register shift (op2[4]=1, op2[7]=0): s=`rs_val`[7:0].
  - s==0: LSL #0, `c_out`=`c_in`, no override, for every type.
  - LSL: s≤31 normal with `c_out`=rm[32-s]; s==32 → override 0, `c_out`=rm[0]; s>32 → override 0, `c_out`=0.
  - LSR: s≤31 normal; s==32 → override 0, `c_out`=rm[31]; s>32 → override 0, `c_out`=0.
  - ASR: s≥32 → override {32{rm[31]}}, `c_out`=rm[31].
  - ROR: s[4:0]==0 with s≠0 → `sh_shamt`=0, `c_out`=rm[31]; otherwise amount s[4:0], `c_out`=rm[s[4:0]-1].
- op2[4]=1 with op2[7]=1 → `undef`=1.
- Decode is combinational on the input side; the decoded payload is written into the buffer.

## Timing
- Reset: buffer empty, `out_valid`=0, `in_ready`=1, all payload outputs 0.
- Transfer occurs when valid&&ready on a rising edge.
- Latency: accepted at edge k → `out_valid`=1 after edge k, payload stable until consumed.
- Throughput: 1 per cycle sustained.
- `in_ready` = buffer not full, registered. It drops the cycle after the second entry fills while `out_ready`=0, and rises the cycle after a pop from full.
- Push and pop in the same cycle with 1 entry: occupancy stays 1, head advances.
- Order is strictly FIFO. Payload must not change while `out_valid`&&!`out_ready`.
- `reset_n` asserted mid-operation: buffer flushes immediately (asynchronous), and any in-flight entries are lost.

## Configuration
- `OPERAND2_REGSHIFT_EN` defined: register-shift forms decoded as above.
- Not defined: every op2[4]=1 encoding yields `undef`=1. `rs_val` is unused, and that logic is removed.

## Test plan
- Immediate op2=0x4FF, `c_in`=0 → `sh_a`=0xFF, `sh_shamt`=8, `sh_sh`=11, `c_out`=1 (rotated bit 31 = 1).
- Immediate shift LSR #0, rm=0x80000001 → `ovr_en`=1, `ovr_val`=0, `c_out`=1. ROR #0 with `c_in`=1, rm=0x3 → `ovr_val`=0x80000001, `c_out`=1.
- Register LSL, rs=32, rm=0x1 → override 0, `c_out`=1. rs=33 → `c_out`=0. rs=0x100 (s=0) → no override, `c_out`=`c_in`.
- Backpressure: 3 back-to-back pushes with `out_ready`=0 → `in_ready` low after 2 are accepted. Release `out_ready` → outputs in order, with no loss or duplication.
- Simultaneous push/pop at occupancy 1 for 10 cycles → `out_valid` stays 1, one result per cycle.
- `reset_n` low with 2 entries held → `out_valid`=0 and `in_ready`=1 immediately; without `OPERAND2_REGSHIFT_EN`, op2=0x010 → `undef`=1.
